// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-only data memory: byte/half extraction
// for loads, read-modify-write for sub-word stores, and access error detection.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [1:0]  resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StMerge  = 2'd2;
    localparam logic [1:0] StResp   = 2'd3;

    localparam logic [1:0] ErrNone    = 2'b00;
    localparam logic [1:0] ErrAlign   = 2'b01;
    localparam logic [1:0] ErrRange   = 2'b10;
    localparam logic [1:0] ErrIllegal = 2'b11;

    localparam logic [31:0] MemLimit = 32'(MEM_BYTES);

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        store_q, store_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] old_q, old_d;
    logic [1:0]  resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic        accept;
    logic [1:0]  req_err;
    logic        is_word_store;
    logic [4:0]  byte_off;
    logic [4:0]  half_off;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign req_ready = (state_q == StIdle);
    assign accept    = req_valid && req_ready;

    // Illegal outranks misaligned, which outranks out-of-range.
    always_comb begin
        req_err = ErrNone;
        if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111 ||
            (req_store && req_funct3[2])) begin
            req_err = ErrIllegal;
        end else if ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                     (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00)) begin
            req_err = ErrAlign;
        end else if (req_addr >= MemLimit) begin
            req_err = ErrRange;
        end
    end

    assign is_word_store = store_q && (funct3_q == 3'b010);
    assign byte_off      = {addr_q[1:0], 3'b000};
    assign half_off      = {addr_q[1], 4'b0000};
    assign byte_sel      = mem_rdata[byte_off +: 8];
    assign half_sel      = mem_rdata[half_off +: 16];

    always_comb begin
        load_ext = mem_rdata;
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'h0, byte_sel};
            3'b101:  load_ext = {16'h0, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        merged = old_q;
        if (funct3_q[0]) begin
            merged[half_off +: 16] = wdata_q[15:0];
        end else begin
            merged[byte_off +: 8] = wdata_q[7:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        store_d      = store_q;
        wdata_d      = wdata_q;
        old_d        = old_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d   = req_addr;
                    funct3_d = req_funct3;
                    store_d  = req_store;
                    wdata_d  = req_wdata;
                    if (req_err != ErrNone) begin
                        resp_err_d   = req_err;
                        resp_rdata_d = 32'h0;
                        state_d      = StResp;
                    end else begin
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                if (!store_q) begin
                    resp_err_d   = ErrNone;
                    resp_rdata_d = load_ext;
                    state_d      = StResp;
                end else if (is_word_store) begin
                    resp_err_d   = ErrNone;
                    resp_rdata_d = 32'h0;
                    state_d      = StResp;
                end else begin
                    old_d   = mem_rdata;
                    state_d = StMerge;
                end
            end
            StMerge: begin
                resp_err_d   = ErrNone;
                resp_rdata_d = 32'h0;
                state_d      = StResp;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= 32'h0;
            funct3_q     <= 3'b000;
            store_q      <= 1'b0;
            wdata_q      <= 32'h0;
            old_q        <= 32'h0;
            resp_err_q   <= ErrNone;
            resp_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            store_q      <= store_d;
            wdata_q      <= wdata_d;
            old_q        <= old_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Strobes are masked by rst so a reset landing in MERGE never commits the write.
    assign mem_read   = !rst && (state_q == StAccess) && !is_word_store;
    assign mem_write  = !rst && (((state_q == StAccess) && is_word_store) ||
                                 (state_q == StMerge));
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_wdata  = (state_q == StMerge) ? merged :
                        ((state_q == StAccess) && is_word_store) ? wdata_q : 32'h0;

    assign resp_valid = (state_q == StResp);
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a word-wide behavioural data memory.
module tb_load_store_unit;

    localparam int unsigned MemBytes = 1024;
    localparam int unsigned Words    = MemBytes / 4;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [1:0]  resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    load_store_unit #(.MEM_BYTES(MemBytes)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [Words];
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(Words); i++) mem[i] <= 32'h0;
        end else if (mem_write) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    int rd_cnt, wr_cnt, both_cnt, resp_cnt, acc_cnt;
    logic [1:0]  err_log [$];
    logic [31:0] rdata_log [$];

    initial begin
        rd_cnt = 0; wr_cnt = 0; both_cnt = 0; resp_cnt = 0; acc_cnt = 0;
    end

    always @(negedge clk) begin
        if (mem_read) rd_cnt++;
        if (mem_write) wr_cnt++;
        if (mem_read && mem_write) both_cnt++;
        if (req_valid && req_ready && !rst) acc_cnt++;
        if (resp_valid) begin
            resp_cnt++;
            err_log.push_back(resp_err);
            rdata_log.push_back(resp_rdata);
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request: wait for ready, present for one accept edge, time the response.
    task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] eerr, input logic [31:0] erd, input int elat);
        int k;
        int r0, w0;
        @(negedge clk);
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        r0 = rd_cnt;
        w0 = wr_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        k = 1;
        while (!resp_valid && k < 10) begin
            @(posedge clk);
            #1 k++;
        end
        check_eq({tag, " latency"}, 32'(k), 32'(elat));
        check_eq({tag, " err"}, 32'(resp_err), 32'(eerr));
        check_eq({tag, " rdata"}, resp_rdata, erd);
        if (eerr != 2'b00) check_eq({tag, " mem ops"}, 32'(rd_cnt - r0 + wr_cnt - w0), 32'd0);
        @(posedge clk);
        #1;
        check_eq({tag, " pulse width"}, 32'(resp_valid), 32'd0);
        check_eq({tag, " rdata held"}, resp_rdata, erd);
    endtask

    initial begin
        int k, w0, r0, base;
        rst        = 1'b1;
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        req_wdata  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        check_eq("reset ready", 32'(req_ready), 32'd1);
        check_eq("reset resp_valid", 32'(resp_valid), 32'd0);
        check_eq("reset resp_err", 32'(resp_err), 32'd0);
        check_eq("reset resp_rdata", resp_rdata, 32'd0);
        check_eq("reset mem strobes", 32'({mem_read, mem_write}), 32'd0);
        check_eq("reset mem_addr", mem_addr, 32'd0);
        check_eq("reset mem_wdata", mem_wdata, 32'd0);
        check_eq("reset accepts", 32'(acc_cnt), 32'd0);

        do_req("SW 10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 2'b00, 32'h0, 2);
        check_eq("mem[10] after SW", mem[4], 32'hDEADBEEF);
        do_req("LW 10",  1'b0, 3'b010, 32'h10, 32'h0, 2'b00, 32'hDEADBEEF, 2);
        do_req("LB 13",  1'b0, 3'b000, 32'h13, 32'h0, 2'b00, 32'hFFFFFFDE, 2);
        do_req("LBU 13", 1'b0, 3'b100, 32'h13, 32'h0, 2'b00, 32'h000000DE, 2);
        do_req("LH 10",  1'b0, 3'b001, 32'h10, 32'h0, 2'b00, 32'hFFFFBEEF, 2);
        do_req("LHU 12", 1'b0, 3'b101, 32'h12, 32'h0, 2'b00, 32'h0000DEAD, 2);
        do_req("SB 11",  1'b1, 3'b000, 32'h11, 32'h12345677, 2'b00, 32'h0, 3);
        check_eq("mem[10] after SB", mem[4], 32'hDEAD77EF);
        do_req("LW after SB", 1'b0, 3'b010, 32'h10, 32'h0, 2'b00, 32'hDEAD77EF, 2);
        do_req("SH 12",  1'b1, 3'b001, 32'h12, 32'hAAAA5555, 2'b00, 32'h0, 3);
        do_req("LW after SH", 1'b0, 3'b010, 32'h10, 32'h0, 2'b00, 32'h555577EF, 2);

        do_req("LW 11 misaligned", 1'b0, 3'b010, 32'h11,  32'h0, 2'b01, 32'h0, 1);
        do_req("LH 13 misaligned", 1'b0, 3'b001, 32'h13,  32'h0, 2'b01, 32'h0, 1);
        do_req("f3 110 illegal",   1'b0, 3'b110, 32'h11,  32'h0, 2'b11, 32'h0, 1);
        do_req("LW 400 range",     1'b0, 3'b010, 32'h400, 32'h0, 2'b10, 32'h0, 1);
        do_req("SB f3 100 illegal", 1'b1, 3'b100, 32'h10, 32'hFF, 2'b11, 32'h0, 1);
        do_req("SW 402 misaligned", 1'b1, 3'b010, 32'h402, 32'h1, 2'b01, 32'h0, 1);
        check_eq("mem[10] after errors", mem[4], 32'h555577EF);

        // Reset landing in MERGE of SB 0x20.
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h20;
        req_wdata  = 32'h000000FF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1;
        w0  = wr_cnt;
        r0  = resp_cnt;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_eq("rst merge ready", 32'(req_ready), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst merge writes", 32'(wr_cnt - w0), 32'd0);
        check_eq("rst merge resp", 32'(resp_cnt - r0), 32'd0);
        check_eq("rst merge mem[20]", mem[8], 32'h0);

        // Back-to-back with req_valid held: SW, LW, SB.
        base = resp_cnt;
        w0   = acc_cnt;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            req_valid  = 1'b1;
            req_store  = (i != 1);
            req_funct3 = (i == 0) ? 3'b010 : (i == 1) ? 3'b010 : 3'b000;
            req_addr   = (i == 2) ? 32'h15 : 32'h14;
            req_wdata  = (i == 0) ? 32'h11223344 : 32'h000000AB;
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!req_ready && k < 20);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        k = 0;
        while (resp_cnt < base + 3 && k < 20) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk);
        #1;
        check_eq("b2b accepts", 32'(acc_cnt - w0), 32'd3);
        check_eq("b2b responses", 32'(resp_cnt - base), 32'd3);
        if (resp_cnt >= base + 3) begin
            check_eq("b2b SW err", 32'(err_log[base]), 32'd0);
            check_eq("b2b LW rdata", rdata_log[base + 1], 32'h11223344);
            check_eq("b2b SB rdata", rdata_log[base + 2], 32'h0);
        end
        check_eq("b2b mem[14]", mem[5], 32'h1122AB44);
        check_eq("never read+write", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
